imem_loader: RTL and testbench

- Boot-time writer for the byte-addressable instruction memory.
- Accepts a framed byte stream over a valid/ready handshake: 16-bit length header, payload, 8-bit checksum.
- Packs payload bytes into little-endian 32-bit words and drives the instruction memory write port.
- Holds the core in reset until a load completes and the checksum is verified.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader.sv | 121 ++++++++++++
 tb/tb_imem_loader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

endpackage

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a length-framed byte stream,
// packs payload bytes into little-endian words, writes them out and releases
// the core once the trailing checksum matches.
//
// state  | meaning
// IDLE   | after reset, core held, waiting for start
// LEN_LO | waiting for length header low byte
// LEN_HI | waiting for length header high byte, then validate length
// DATA   | consuming payload bytes, one memory write per 4 bytes
// CSUM   | waiting for checksum byte
// DONE   | load good, core released
// ERR    | load aborted, err_code holds the reason
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 128,
  parameter int AW        = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          we,
  output logic [AW-1:0] wa,
  output logic [31:0]   wd,
  output logic          core_hold,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MEM_BYTES);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] count;
  logic [7:0]       sum;
  // Lanes 0..2 of the word being assembled; lane 3 goes straight into wd
  // together with these on the completing byte.
  logic [23:0]      pack;

  logic             xfer;
  logic [LEN_W-1:0] len_full;
  logic             len_bad;

  assign xfer     = in_valid && in_ready;
  assign len_full = {in_data, len[7:0]};
  assign len_bad  = (len_full == '0) || (len_full[1:0] != 2'b00) || (len_full > MAX_LEN);

  // Status outputs are pure functions of the state.
  always_comb begin
    in_ready  = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CSUM);
    done      = (state == DONE);
    err       = (state == ERR);
    core_hold = (state != DONE);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = LEN_LO;
      LEN_LO:          if (xfer) state_nxt = LEN_HI;
      LEN_HI:          if (xfer) state_nxt = len_bad ? ERR : DATA;
      DATA:            if (xfer && (count == len - LEN_W'(1))) state_nxt = CSUM;
      CSUM:            if (xfer) state_nxt = (in_data == sum) ? DONE : ERR;
      default:         state_nxt = IDLE;
    endcase
  end

  // Header capture, payload packing, checksum accumulation and write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len      <= '0;
      count    <= '0;
      sum      <= '0;
      pack     <= '0;
      we       <= 1'b0;
      wa       <= '0;
      wd       <= '0;
      err_code <= ERR_NONE;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: if (start) err_code <= ERR_NONE;
        LEN_LO: if (xfer) len[7:0] <= in_data;
        LEN_HI: if (xfer) begin
          len[15:8] <= in_data;
          count     <= '0;
          sum       <= '0;
          if (len_bad) err_code <= ERR_LEN;
        end
        DATA: if (xfer) begin
          sum   <= sum + in_data;
          count <= count + LEN_W'(1);
          case (count[1:0])
            2'd0: pack[7:0]   <= in_data;
            2'd1: pack[15:8]  <= in_data;
            2'd2: pack[23:16] <= in_data;
            default: begin
              we <= 1'b1;
              wa <= AW'({count[LEN_W-1:2], 2'b00});
              wd <= {in_data, pack};
            end
          endcase
        end
        CSUM: if (xfer && (in_data != sum)) err_code <= ERR_CSUM;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a
// negedge monitor pops and compares whenever we is high.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        core_hold;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb[$];
  logic [7:0]  stream[$];

  imem_loader #(.MEM_BYTES(128), .AW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .core_hold (core_hold),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && we) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=wa:%h wd:%h expected=no write", wa, wd);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({wa, wd} !== e) begin
          failures++;
          $display("FAIL write actual=wa:%h wd:%h expected=wa:%h wd:%h",
                   wa, wd, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte transferred.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready:0 expected=in_ready:1 byte=%h", b);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input int max_gap);
    foreach (stream[i]) send(stream[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'h0);
    chk({tag, "_we"},        32'(we),        32'h0);
    chk({tag, "_wa"},        wa,             32'h0);
    chk({tag, "_wd"},        wd,             32'h0);
    chk({tag, "_core_hold"}, 32'(core_hold), 32'h1);
    chk({tag, "_done"},      32'(done),      32'h0);
    chk({tag, "_err"},       32'(err),       32'h0);
    chk({tag, "_err_code"},  32'(err_code),  32'h0);
  endtask

  task automatic chk_status(input string tag, input logic d, input logic e, input logic [1:0] c, input logic h);
    chk({tag, "_done"},      32'(done),      32'(d));
    chk({tag, "_err"},       32'(err),       32'(e));
    chk({tag, "_err_code"},  32'(err_code),  32'(c));
    chk({tag, "_core_hold"}, 32'(core_hold), 32'(h));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #2 reset = 1'b1;
    #1 chk_reset_vals("reset");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Good load, gap-free.
    pulse_start();
    sb.push_back({32'h0, 32'h00F00093});
    sb.push_back({32'h4, 32'h01600113});
    stream = '{8'h08, 8'h00, 8'h93, 8'h00, 8'hF0, 8'h00, 8'h13, 8'h01, 8'h60, 8'h01, 8'hF8};
    send_stream(0);
    chk_status("good", 1'b1, 1'b0, 2'b00, 1'b0);
    chk("good_drain", 32'(sb.size()), 32'h0);

    // Same payload with gaps and a wrong checksum.
    pulse_start();
    sb.push_back({32'h0, 32'h00F00093});
    sb.push_back({32'h4, 32'h01600113});
    stream = '{8'h08, 8'h00, 8'h93, 8'h00, 8'hF0, 8'h00, 8'h13, 8'h01, 8'h60, 8'h01, 8'hF7};
    send_stream(3);
    chk_status("csum", 1'b0, 1'b1, 2'b10, 1'b1);
    chk("csum_in_ready", 32'(in_ready), 32'h0);
    chk("csum_drain", 32'(sb.size()), 32'h0);

    // Bad lengths: not a multiple of 4, too large, zero.
    pulse_start();
    chk_status("restart_err", 1'b0, 1'b0, 2'b00, 1'b1);
    send(8'h06, 0); send(8'h00, 0);
    chk_status("len6", 1'b0, 1'b1, 2'b01, 1'b1);
    pulse_start();
    send(8'h84, 0); send(8'h00, 0);
    chk_status("len132", 1'b0, 1'b1, 2'b01, 1'b1);
    pulse_start();
    send(8'h00, 0); send(8'h00, 0);
    chk_status("len0", 1'b0, 1'b1, 2'b01, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    chk("len_hold_err_code", 32'(err_code), 32'h1);

    // Reset after the 5th payload byte of a length-8 load.
    pulse_start();
    sb.push_back({32'h0, 32'h00F00093});
    stream = '{8'h08, 8'h00, 8'h93, 8'h00, 8'hF0, 8'h00, 8'h13};
    send_stream(0);
    reset = 1'b1;
    #1 chk_reset_vals("midreset");
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midreset_drain", 32'(sb.size()), 32'h0);
    chk("midreset_idle_ready", 32'(in_ready), 32'h0);

    // Reload after reset, with a start pulse in DATA that must be ignored.
    pulse_start();
    sb.push_back({32'h0, 32'h00F00093});
    sb.push_back({32'h4, 32'h01600113});
    send(8'h08, 0); send(8'h00, 0);
    send(8'h93, 0); send(8'h00, 0); send(8'hF0, 0);
    pulse_start();
    chk("start_in_data_ready", 32'(in_ready), 32'h1);
    send(8'h00, 0); send(8'h13, 0); send(8'h01, 0); send(8'h60, 0); send(8'h01, 0);
    send(8'hF8, 0);
    chk_status("reload", 1'b1, 1'b0, 2'b00, 1'b0);
    chk("reload_drain", 32'(sb.size()), 32'h0);

    // start in DONE restarts; second 4-byte load.
    pulse_start();
    chk_status("restart_done", 1'b0, 1'b0, 2'b00, 1'b1);
    chk("restart_done_ready", 32'(in_ready), 32'h1);
    sb.push_back({32'h0, 32'h002081B3});
    stream = '{8'h04, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h00, 8'h54};
    send_stream(0);
    chk_status("load4", 1'b1, 1'b0, 2'b00, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    chk("load4_drain", 32'(sb.size()), 32'h0);
    chk("load4_wa_hold", wa, 32'h0);
    chk("load4_wd_hold", wd, 32'h002081B3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
